// File: rtl/id_operand_unit_pkg.sv
// rtl/id_operand_unit_pkg.sv - shared widths, back-bus field positions and branch codes
package id_operand_unit_pkg;

  localparam int BACK_W      = 38;
  localparam int BACK_WE_BIT = 37;
  localparam int BACK_WD_HI  = 36;
  localparam int BACK_WD_LO  = 5;
  localparam int BACK_RW_HI  = 4;
  localparam int BACK_RW_LO  = 0;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLEZ = 3'd5,
    BR_BLTZ = 3'd6,
    BR_RSVD = 3'd7
  } branch_type_e;

  function automatic logic back_we(input logic [BACK_W-1:0] b);
    return b[BACK_WE_BIT];
  endfunction

  function automatic logic [31:0] back_wd(input logic [BACK_W-1:0] b);
    return b[BACK_WD_HI:BACK_WD_LO];
  endfunction

  function automatic logic [4:0] back_rw(input logic [BACK_W-1:0] b);
    return b[BACK_RW_HI:BACK_RW_LO];
  endfunction

endpackage

// File: rtl/id_operand_unit_if.sv
// rtl/id_operand_unit_if.sv - decode-stage operand bus between pipeline and operand unit
interface id_operand_unit_if;
  import id_operand_unit_pkg::*;

  logic              flush;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [31:0]       rd1;
  logic [31:0]       rd2;
  logic [15:0]       imm;
  logic              extop;
  logic              exsign;
  logic [2:0]        branch_type;
  logic [BACK_W-1:0] mem_back;
  logic [BACK_W-1:0] wb_back;
  logic              use_mem_back;
  logic              use_wb_back;
  logic [31:0]       f_rd1;
  logic [31:0]       f_rd2;
  logic [31:0]       ext_b;
  logic              branch_avail;
  logic [31:0]       q_rd1;
  logic [31:0]       q_rd2;
  logic [31:0]       q_ext;

  modport master (
    output flush, rs, rt, rd1, rd2, imm, extop, exsign, branch_type,
           mem_back, wb_back, use_mem_back, use_wb_back,
    input  f_rd1, f_rd2, ext_b, branch_avail, q_rd1, q_rd2, q_ext
  );

  modport slave (
    input  flush, rs, rt, rd1, rd2, imm, extop, exsign, branch_type,
           mem_back, wb_back, use_mem_back, use_wb_back,
    output f_rd1, f_rd2, ext_b, branch_avail, q_rd1, q_rd2, q_ext
  );

endinterface

// File: rtl/id_operand_unit_branch.sv
// rtl/id_operand_unit_branch.sv - signed branch condition evaluation
module branch_unit
  import id_operand_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  branch_type,
  output logic        taken
);

  logic signed [31:0] sa;
  assign sa = a;

  // Code 0 and the reserved code never take the branch.
  always_comb begin
    taken = 1'b0;
    case (branch_type)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BGEZ: taken = (sa >= 0);
      BR_BGTZ: taken = (sa > 0);
      BR_BLEZ: taken = (sa <= 0);
      BR_BLTZ: taken = (sa < 0);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_operand_unit_ext.sv
// rtl/id_operand_unit_ext.sv - immediate extender (upper / sign / zero)
module ext_unit (
  input  logic [15:0] imm,
  input  logic        extop,
  input  logic        exsign,
  output logic [31:0] ext_b
);

  // Load-upper form takes priority over the sign selection.
  always_comb begin
    ext_b = {16'h0000, imm};
    if (extop)
      ext_b = {imm, 16'h0000};
    else if (exsign)
      ext_b = {{16{imm[15]}}, imm};
  end

endmodule

// File: rtl/id_operand_unit_fwd.sv
// rtl/id_operand_unit_fwd.sv - bypass muxes for both source operands
module fwd_unit
  import id_operand_unit_pkg::*;
(
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  input  logic [BACK_W-1:0] mem_back,
  input  logic [BACK_W-1:0] wb_back,
  input  logic              use_mem_back,
  input  logic              use_wb_back,
  output logic [31:0]       f_rd1,
  output logic [31:0]       f_rd2
);

  function automatic logic hit(input logic en, input logic [BACK_W-1:0] b,
                               input logic [4:0] r);
    return en && back_we(b) && (back_rw(b) != 5'd0) && (back_rw(b) == r);
  endfunction

  // Mem stage holds the newer result, so it is checked before write-back.
  function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] rf);
    if (hit(use_mem_back, mem_back, r))
      return back_wd(mem_back);
    else if (hit(use_wb_back, wb_back, r))
      return back_wd(wb_back);
    else
      return rf;
  endfunction

  // One mux per operand sharing the same priority rule.
  always_comb begin
    f_rd1 = pick(rs, rd1);
    f_rd2 = pick(rt, rd2);
  end

endmodule

// File: rtl/id_operand_unit.sv
// rtl/id_operand_unit.sv - decode operand unit: forwarding, extension, branch, ID/EX register
module id_operand_unit
  import id_operand_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  id_operand_unit_if.slave bus
);

  logic [31:0] f_rd1;
  logic [31:0] f_rd2;
  logic [31:0] ext_b;
  logic        taken;

  fwd_unit u_fwd (
    .rs           (bus.rs),
    .rt           (bus.rt),
    .rd1          (bus.rd1),
    .rd2          (bus.rd2),
    .mem_back     (bus.mem_back),
    .wb_back      (bus.wb_back),
    .use_mem_back (bus.use_mem_back),
    .use_wb_back  (bus.use_wb_back),
    .f_rd1        (f_rd1),
    .f_rd2        (f_rd2)
  );

  ext_unit u_ext (
    .imm    (bus.imm),
    .extop  (bus.extop),
    .exsign (bus.exsign),
    .ext_b  (ext_b)
  );

  branch_unit u_branch (
    .a           (f_rd1),
    .b           (f_rd2),
    .branch_type (bus.branch_type),
    .taken       (taken)
  );

  assign bus.f_rd1        = f_rd1;
  assign bus.f_rd2        = f_rd2;
  assign bus.ext_b        = ext_b;
  assign bus.branch_avail = taken;

  // Pipeline register; reset and flush both insert a zero bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bus.q_rd1 <= '0;
      bus.q_rd2 <= '0;
      bus.q_ext <= '0;
    end else begin
      bus.q_rd1 <= f_rd1;
      bus.q_rd2 <= f_rd2;
      bus.q_ext <= ext_b;
    end
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// tb/tb_id_operand_unit.sv - directed self-checking bench for id_operand_unit
module tb_id_operand_unit;
  import id_operand_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  id_operand_unit_if bus ();

  id_operand_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic [BACK_W-1:0] mk_back(input logic we, input logic [31:0] wd,
                                                input logic [4:0] rw);
    return {we, wd, rw};
  endfunction

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush = 1'b0; bus.rs = '0; bus.rt = '0; bus.rd1 = '0; bus.rd2 = '0;
    bus.imm = '0; bus.extop = 1'b0; bus.exsign = 1'b0; bus.branch_type = 3'd0;
    bus.mem_back = '0; bus.wb_back = '0; bus.use_mem_back = 1'b0; bus.use_wb_back = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_q_rd1", bus.q_rd1, 32'h0);
    check("rst_q_rd2", bus.q_rd2, 32'h0);
    check("rst_q_ext", bus.q_ext, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Forwarding priority
    bus.rs = 5'd5; bus.rd1 = 32'h1; bus.rt = 5'd5; bus.rd2 = 32'h2;
    bus.mem_back = mk_back(1'b1, 32'hAAAA0000, 5'd5);
    bus.wb_back  = mk_back(1'b1, 32'hBBBB0000, 5'd5);
    bus.use_mem_back = 1'b1; bus.use_wb_back = 1'b1; settle();
    check("fwd_mem_wins", bus.f_rd1, 32'hAAAA0000);
    check("fwd_rt_mem", bus.f_rd2, 32'hAAAA0000);
    bus.use_mem_back = 1'b0; settle();
    check("fwd_wb", bus.f_rd1, 32'hBBBB0000);
    bus.use_wb_back = 1'b0; settle();
    check("fwd_none", bus.f_rd1, 32'h1);
    bus.use_mem_back = 1'b1; bus.rt = 5'd6; settle();
    check("fwd_rt_miss", bus.f_rd2, 32'h2);

    // Register 0 and regWrite=0 never forward
    bus.rs = 5'd0; bus.rd1 = 32'h12345678;
    bus.mem_back = mk_back(1'b1, 32'hDEADBEEF, 5'd0);
    bus.wb_back  = mk_back(1'b1, 32'hCAFEF00D, 5'd0);
    bus.use_wb_back = 1'b1; settle();
    check("fwd_r0", bus.f_rd1, 32'h12345678);
    bus.rs = 5'd9; bus.use_wb_back = 1'b0;
    bus.mem_back = mk_back(1'b0, 32'hDEADBEEF, 5'd9); settle();
    check("fwd_no_we", bus.f_rd1, 32'h12345678);

    // Immediate extension
    bus.imm = 16'h8001; bus.extop = 1'b0; bus.exsign = 1'b1; settle();
    check("ext_sign", bus.ext_b, 32'hFFFF8001);
    bus.exsign = 1'b0; settle();
    check("ext_zero", bus.ext_b, 32'h00008001);
    bus.extop = 1'b1; settle();
    check("ext_lui", bus.ext_b, 32'h80010000);
    bus.exsign = 1'b1; settle();
    check("ext_lui_sign", bus.ext_b, 32'h80010000);
    bus.extop = 1'b0; bus.imm = 16'h7FFF; settle();
    check("ext_sign_pos", bus.ext_b, 32'h00007FFF);

    // Branch conditions, no forwarding
    bus.use_mem_back = 1'b0; bus.use_wb_back = 1'b0;
    bus.rs = 5'd1; bus.rt = 5'd2; bus.rd1 = 32'd7; bus.rd2 = 32'd7;
    bus.branch_type = 3'd1; settle(); check("br_beq", {31'b0, bus.branch_avail}, 32'd1);
    bus.branch_type = 3'd2; settle(); check("br_bne", {31'b0, bus.branch_avail}, 32'd0);
    bus.branch_type = 3'd0; settle(); check("br_none", {31'b0, bus.branch_avail}, 32'd0);
    bus.rd1 = 32'hFFFFFFFF;
    bus.branch_type = 3'd6; settle(); check("br_bltz_neg", {31'b0, bus.branch_avail}, 32'd1);
    bus.branch_type = 3'd2; settle(); check("br_bne_diff", {31'b0, bus.branch_avail}, 32'd1);
    bus.rd1 = 32'h0;
    bus.branch_type = 3'd4; settle(); check("br_bgtz_zero", {31'b0, bus.branch_avail}, 32'd0);
    bus.branch_type = 3'd5; settle(); check("br_blez_zero", {31'b0, bus.branch_avail}, 32'd1);
    bus.branch_type = 3'd3; settle(); check("br_bgez_zero", {31'b0, bus.branch_avail}, 32'd1);
    bus.branch_type = 3'd6; settle(); check("br_bltz_zero", {31'b0, bus.branch_avail}, 32'd0);
    bus.branch_type = 3'd7; settle(); check("br_rsvd", {31'b0, bus.branch_avail}, 32'd0);
    bus.rd1 = 32'h80000000;
    bus.branch_type = 3'd3; settle(); check("br_bgez_min", {31'b0, bus.branch_avail}, 32'd0);
    bus.branch_type = 3'd4; settle(); check("br_bgtz_min", {31'b0, bus.branch_avail}, 32'd0);
    bus.branch_type = 3'd5; settle(); check("br_blez_min", {31'b0, bus.branch_avail}, 32'd1);

    // Branch on forwarded operand
    bus.rd1 = 32'h0; bus.rs = 5'd3;
    bus.mem_back = mk_back(1'b1, 32'd3, 5'd3); bus.use_mem_back = 1'b1;
    bus.branch_type = 3'd4; settle();
    check("br_fwd_bgtz", {31'b0, bus.branch_avail}, 32'd1);

    // Registered capture, flush and reset
    @(negedge clk);
    bus.rs = 5'd3; bus.rt = 5'd2; bus.rd1 = 32'd11; bus.rd2 = 32'd22;
    bus.imm = 16'h8001; bus.extop = 1'b0; bus.exsign = 1'b1;
    @(posedge clk); #1;
    check("cap_q_rd1_fwd", bus.q_rd1, 32'd3);
    check("cap_q_rd2", bus.q_rd2, 32'd22);
    check("cap_q_ext", bus.q_ext, 32'hFFFF8001);
    @(negedge clk);
    bus.flush = 1'b1; settle();
    check("flush_comb", bus.f_rd1, 32'd3);
    @(posedge clk); #1;
    check("flush_q_rd1", bus.q_rd1, 32'h0);
    check("flush_q_rd2", bus.q_rd2, 32'h0);
    check("flush_q_ext", bus.q_ext, 32'h0);
    @(negedge clk);
    bus.flush = 1'b0; bus.use_mem_back = 1'b0;
    @(posedge clk); #1;
    check("recap_q_rd1", bus.q_rd1, 32'd11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_q_rd1", bus.q_rd1, 32'h0);
    check("rst_mid_q_ext", bus.q_ext, 32'h0);
    check("rst_mid_comb", bus.f_rd2, 32'd22);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_q_rd2", bus.q_rd2, 32'd22);
    @(negedge clk);
    rst = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    check("rst_flush_q_rd2", bus.q_rd2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_operand_unit.md
ID_OPERAND_UNIT -- requirements
Module: id_operand_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: flush  in  1  clears output register on next edge; rs, rt  in  5 each  source register numbers.
REQ-003 SHALL have: rd1, rd2  in  32 each  register-file read data for rs/rt; imm  in  16  instruction immediate.
REQ-004 SHALL have: extop  in  1  1=load-upper form; exsign  in  1  1=sign-extend, 0=zero-extend; branch_type  in  3  branch condition code.
REQ-005 SHALL have: mem_back, wb_back  in  38 each  write-back buses packed {regWrite[37], Wd[36:5], rw[4:0]}; use_mem_back, use_wb_back  in  1 each  forwarding-source enables.
REQ-006 SHALL have combinational outputs: f_rd1, f_rd2  out  32  forwarded operands; ext_b  out  32  extended immediate; branch_avail  out  1  branch taken.
REQ-007 SHALL have registered outputs: q_rd1, q_rd2, q_ext  out  32 each  captured f_rd1/f_rd2/ext_b.

Function
REQ-008 Forwarding per operand: mem_back wins if use_mem_back, mem regWrite=1, mem rw!=0, mem rw==rs (rt for f_rd2); else wb_back under the same rules with use_wb_back; else rd1 (rd2).
REQ-009 Register 0 SHALL never be forwarded; rs=0 always yields rd1 unchanged.
REQ-010 When mem and wb both match, mem Wd SHALL be selected (newer value).
REQ-011 ext_b: extop=1 -> {imm,16'h0000} regardless of exsign; extop=0, exsign=1 -> imm sign-extended; extop=0, exsign=0 -> imm zero-extended.
REQ-012 branch_avail from f_rd1 (A) and f_rd2 (B), signed compares: 0 none->0; 1 BEQ A==B; 2 BNE A!=B; 3 BGEZ A>=0; 4 BGTZ A>0; 5 BLEZ A<=0; 6 BLTZ A<0; 7 reserved->0.
REQ-013 Combinational outputs SHALL settle within the cycle, no internal state.
REQ-014 On each rising edge: rst=1 or flush=1 -> q_rd1, q_rd2, q_ext = 0; else capture f_rd1, f_rd2, ext_b (latency 1 cycle).
REQ-015 rst and flush simultaneously SHALL behave as rst; flush has no effect on combinational outputs.

Reset
REQ-016 Reset SHALL be synchronous, active-high; q_rd1, q_rd2, q_ext SHALL read 0 after reset edge and at power-up (initial zero).
REQ-017 Reset asserted mid-operation SHALL clear registered outputs on that edge only; combinational paths unaffected.

Structure
REQ-018 Shared package SHALL hold bus width (38), field positions of the back bus, and branch_type codes 0-7 as named constants.
REQ-019 Sub-modules: ext_unit, fwd_unit (instanced once, two operand muxes), branch_unit; top holds the output register only.

Verification
REQ-020 rs=5, rd1=1, mem_back={1,32'hAAAA0000,5}, wb_back={1,32'hBBBB0000,5}, both enables 1 -> f_rd1=AAAA0000; use_mem_back=0 -> BBBB0000.
REQ-021 rs=0, mem_back={1,32'hDEADBEEF,0} -> f_rd1=rd1; mem regWrite=0 with rw=rs -> no forward.
REQ-022 imm=16'h8001: exsign=1,extop=0 -> FFFF8001; exsign=0 -> 00008001; extop=1 -> 80010000.
REQ-023 branch_type=1, A=B=7 -> 1; type 2 same -> 0; type 6 A=FFFFFFFF -> 1; type 4 A=0 -> 0; type 5 A=0 -> 1; type 7 -> 0.
REQ-024 Branch using forwarded value: rd1=0, mem forwards 3 to rs, type 4 -> branch_avail=1.
REQ-025 Drive values, edge -> q_* match; flush=1 edge -> all q_*=0; rst=1 with flush=0 edge -> 0.
